// File: rtl/led_sequencer_if.sv
// ROM-read and LED-write bus used by led_sequencer.
// master = the sequencer, slave = the ROM / LED side.
interface led_sequencer_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [AddrWidth-1:0] rom_addr;
  logic                 rom_read_req;
  logic [DataWidth-1:0] rom_read_data;
  logic                 rom_read_data_valid;
  logic                 led_write_req;
  logic [DataWidth-1:0] led_write_data;
  logic [3:0]           led_byte_enable;

  modport master (
    output rom_addr,
    output rom_read_req,
    input  rom_read_data,
    input  rom_read_data_valid,
    output led_write_req,
    output led_write_data,
    output led_byte_enable
  );

  modport slave (
    input  rom_addr,
    input  rom_read_req,
    output rom_read_data,
    output rom_read_data_valid,
    input  led_write_req,
    input  led_write_data,
    input  led_byte_enable
  );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: walks a pattern table in ROM, writes each word to the LED
// port, then holds it for HoldCycles cycles. Supports start/stop control
// and either looping playback or a one-shot pass ending in DONE.
module led_sequencer #(
  parameter int           AddrWidth  = 32,
  parameter int           DataWidth  = 32,
  parameter int           Depth      = 5,
  parameter int           HoldCycles = 4,
  parameter int           Loop       = 1,
  parameter logic [3:0]   ByteEnable = 4'h1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic [AddrWidth-1:0] step_index,
  led_sequencer_if.master      bus
);

  localparam int                   CntWidth  = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [CntWidth-1:0]  HoldLast  = CntWidth'(HoldCycles - 1);
  localparam logic [AddrWidth-1:0] LastIndex = AddrWidth'(Depth - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    WRITE,
    HOLD,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [AddrWidth-1:0]  step_next;
  logic [CntWidth-1:0]   hold_count;
  logic [CntWidth-1:0]   count_next;
  logic [DataWidth-1:0]  data_reg;
  logic [DataWidth-1:0]  data_next;
  logic                  read_req_q;
  logic                  write_req_q;

  // Next-state decision; stop overrides every other transition, including start.
  always_comb begin
    state_next = state;
    step_next  = step_index;
    count_next = hold_count;
    data_next  = data_reg;
    if (stop) begin
      state_next = IDLE;
      step_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = FETCH;
            step_next  = '0;
          end
        end
        FETCH: begin
          state_next = WAIT_DATA;
        end
        WAIT_DATA: begin
          if (bus.rom_read_data_valid) begin
            data_next  = bus.rom_read_data;
            state_next = WRITE;
          end
        end
        WRITE: begin
          count_next = HoldLast;
          state_next = HOLD;
        end
        HOLD: begin
          if (hold_count == '0) begin
            if (step_index < LastIndex) begin
              step_next  = step_index + AddrWidth'(1);
              state_next = FETCH;
            end else if (Loop != 0) begin
              step_next  = '0;
              state_next = FETCH;
            end else begin
              state_next = DONE;
            end
          end else begin
            count_next = hold_count - CntWidth'(1);
          end
        end
        DONE: begin
          if (start) begin
            step_next  = '0;
            state_next = FETCH;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status/strobe outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      step_index  <= '0;
      hold_count  <= '0;
      data_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      read_req_q  <= 1'b0;
      write_req_q <= 1'b0;
    end else begin
      state       <= state_next;
      step_index  <= step_next;
      hold_count  <= count_next;
      data_reg    <= data_next;
      busy        <= (state_next == FETCH) || (state_next == WAIT_DATA) ||
                     (state_next == WRITE) || (state_next == HOLD);
      done        <= (state_next == DONE);
      read_req_q  <= (state_next == FETCH);
      write_req_q <= (state_next == WRITE);
    end
  end

  assign bus.rom_addr        = step_index;
  assign bus.rom_read_req    = read_req_q;
  assign bus.led_write_req   = write_req_q;
  assign bus.led_write_data  = data_reg;
  assign bus.led_byte_enable = ByteEnable;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: dut_a is one-shot (Loop=0), dut_b loops.
// Expected LED writes (value, index, cycle) are queued when playback is started
// and popped by per-DUT monitors whenever led_write_req is seen.
module tb_led_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic a_start, a_stop, a_busy, a_done;
  logic b_start, b_stop, b_busy, b_done;
  logic [AW-1:0] a_step, b_step;

  always #5 clk = ~clk;

  led_sequencer_if #(.AddrWidth(AW), .DataWidth(DW)) a_bus ();
  led_sequencer_if #(.AddrWidth(AW), .DataWidth(DW)) b_bus ();

  led_sequencer #(
    .AddrWidth(AW), .DataWidth(DW), .Depth(5), .HoldCycles(4), .Loop(0), .ByteEnable(4'h1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop),
    .busy(a_busy), .done(a_done), .step_index(a_step), .bus(a_bus)
  );

  led_sequencer #(
    .AddrWidth(AW), .DataWidth(DW), .Depth(5), .HoldCycles(4), .Loop(1), .ByteEnable(4'h1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
    .busy(b_busy), .done(b_done), .step_index(b_step), .bus(b_bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    int            cyc;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int a_rd = 0, a_wr = 0, b_wr = 0, b_drops = 0;
  logic b_watch = 1'b0;

  // ROM A model controls
  int            a_extra = 0;
  logic          a_stray = 1'b0;
  logic          a_pend  = 1'b0;
  int            a_cnt   = 0;
  logic [AW-1:0] a_paddr = '0;

  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    case (a)
      32'd0:   return 32'h1;
      32'd1:   return 32'h2;
      32'd2:   return 32'h4;
      32'd3:   return 32'h8;
      32'd4:   return 32'hF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a one-cycle start/stop pulse on DUT sel (0=A, 1=B); returns one negedge later
  task automatic applyStimulus(input bit sel, input logic do_start, input logic do_stop);
    if (sel == 1'b0) begin a_start = do_start; a_stop = do_stop; end
    else             begin b_start = do_start; b_stop = do_stop; end
    @(negedge clk);
    a_start = 1'b0; a_stop = 1'b0;
    b_start = 1'b0; b_stop = 1'b0;
  endtask

  task automatic pushPlay(input bit sel, input int s, input int extra, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = AW'(k % 5);
      e.data = romWord(AW'(k % 5));
      e.cyc  = s + 3 + extra + (7 + extra) * k;
      if (sel == 1'b0) a_q.push_back(e);
      else             b_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ROM A: 1-cycle latency plus optional extra delay and injectable stray valid
  always @(posedge clk) begin
    a_bus.rom_read_data_valid <= 1'b0;
    if (a_pend) begin
      if (a_cnt == 0) begin
        a_bus.rom_read_data_valid <= 1'b1;
        a_bus.rom_read_data       <= romWord(a_paddr);
        a_pend                    <= 1'b0;
      end else begin
        a_cnt <= a_cnt - 1;
      end
    end
    if (a_bus.rom_read_req) begin
      if (a_extra == 0) begin
        a_bus.rom_read_data_valid <= 1'b1;
        a_bus.rom_read_data       <= romWord(a_bus.rom_addr);
      end else begin
        a_pend  <= 1'b1;
        a_cnt   <= a_extra - 1;
        a_paddr <= a_bus.rom_addr;
      end
    end
    if (a_stray) begin
      a_bus.rom_read_data_valid <= 1'b1;
      a_bus.rom_read_data       <= 32'hDEAD;
    end
  end

  // ROM B: plain 1-cycle latency
  always @(posedge clk) begin
    b_bus.rom_read_data_valid <= b_bus.rom_read_req;
    b_bus.rom_read_data       <= romWord(b_bus.rom_addr);
  end

  // Monitor A: count strobes, pop and compare each LED write
  always @(negedge clk) begin
    if (a_bus.rom_read_req) a_rd++;
    if (a_bus.led_write_req) begin
      a_wr++;
      if (a_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL a_unexpected_write actual=%0h expected=none (cycle %0d)", a_bus.led_write_data, cyc);
      end else begin
        a_e = a_q.pop_front();
        checkOutput("a_wr_data", 64'(a_bus.led_write_data), 64'(a_e.data));
        checkOutput("a_wr_index", 64'(a_bus.rom_addr), 64'(a_e.idx));
        checkOutput("a_wr_cycle", 64'(cyc), 64'(a_e.cyc));
      end
    end
  end

  // Monitor B: pop and compare each LED write, watch for busy dropping
  always @(negedge clk) begin
    if (b_watch && !b_busy) b_drops++;
    if (b_bus.led_write_req) begin
      b_wr++;
      if (b_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL b_unexpected_write actual=%0h expected=none (cycle %0d)", b_bus.led_write_data, cyc);
      end else begin
        b_e = b_q.pop_front();
        checkOutput("b_wr_data", 64'(b_bus.led_write_data), 64'(b_e.data));
        checkOutput("b_wr_index", 64'(b_bus.rom_addr), 64'(b_e.idx));
        checkOutput("b_wr_cycle", 64'(cyc), 64'(b_e.cyc));
      end
    end
  end

  // Directed test sequence
  initial begin
    int s, rd0, wr0;
    a_start = 1'b0; a_stop = 1'b0;
    b_start = 1'b0; b_stop = 1'b0;
    reset   = 1'b1;

    // T1: reset state and quiet idle
    repeat (3) @(negedge clk);
    checkOutput("t1_busy", 64'(a_busy), 64'd0);
    checkOutput("t1_done", 64'(a_done), 64'd0);
    checkOutput("t1_step", 64'(a_step), 64'd0);
    checkOutput("t1_rd_req", 64'(a_bus.rom_read_req), 64'd0);
    checkOutput("t1_wr_req", 64'(a_bus.led_write_req), 64'd0);
    checkOutput("t1_wr_data", 64'(a_bus.led_write_data), 64'd0);
    checkOutput("t1_byte_en", 64'(a_bus.led_byte_enable), 64'h1);
    checkOutput("t1_b_busy", 64'(b_busy), 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t1_idle_rd", 64'(a_rd), 64'd0);
    checkOutput("t1_idle_wr", 64'(a_wr), 64'd0);

    // T2: one-shot pass, done timing
    s = cyc; rd0 = a_rd; wr0 = a_wr;
    pushPlay(1'b0, s, 0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (34) @(negedge clk);
    checkOutput("t2_done_early", 64'(a_done), 64'd0);
    checkOutput("t2_busy_early", 64'(a_busy), 64'd1);
    @(negedge clk);
    checkOutput("t2_done", 64'(a_done), 64'd1);
    checkOutput("t2_busy", 64'(a_busy), 64'd0);
    checkOutput("t2_step_last", 64'(a_step), 64'd4);
    checkOutput("t2_rd_count", 64'(a_rd - rd0), 64'd5);
    checkOutput("t2_wr_count", 64'(a_wr - wr0), 64'd5);
    checkOutput("t2_queue", 64'(a_q.size()), 64'd0);

    // T4: stop during HOLD of entry 2, then replay from entry 0
    s = cyc; rd0 = a_rd; wr0 = a_wr;
    pushPlay(1'b0, s, 0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (18) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_busy", 64'(a_busy), 64'd0);
    checkOutput("t4_done", 64'(a_done), 64'd0);
    checkOutput("t4_step", 64'(a_step), 64'd0);
    repeat (15) @(negedge clk);
    checkOutput("t4_rd_count", 64'(a_rd - rd0), 64'd3);
    checkOutput("t4_wr_count", 64'(a_wr - wr0), 64'd3);
    checkOutput("t4_data_kept", 64'(a_bus.led_write_data), 64'h4);
    s = cyc;
    pushPlay(1'b0, s, 0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (35) @(negedge clk);
    checkOutput("t4_replay_done", 64'(a_done), 64'd1);

    // T5: stop from DONE, start+stop together, start while busy
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_done_cleared", 64'(a_done), 64'd0);
    rd0 = a_rd;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t5_both_busy", 64'(a_busy), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("t5_both_rd", 64'(a_rd - rd0), 64'd0);
    s = cyc; rd0 = a_rd;
    pushPlay(1'b0, s, 0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (23) @(negedge clk);
    checkOutput("t5_busy_start_done", 64'(a_done), 64'd1);
    checkOutput("t5_busy_start_rd", 64'(a_rd - rd0), 64'd5);

    // T6: ROM valid delayed 3 cycles, stray valid during HOLD
    a_extra = 3;
    s = cyc;
    pushPlay(1'b0, s, 3, 5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    a_stray = 1'b1;
    @(negedge clk);
    a_stray = 1'b0;
    @(negedge clk);
    checkOutput("t6_stray_data", 64'(a_bus.led_write_data), 64'h1);
    checkOutput("t6_stray_step", 64'(a_step), 64'd0);
    repeat (42) @(negedge clk);
    checkOutput("t6_done", 64'(a_done), 64'd1);
    checkOutput("t6_queue", 64'(a_q.size()), 64'd0);

    // T7: reset mid-operation with a ROM response still in flight
    a_extra = 0;
    wr0 = a_wr;
    applyStimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t7_busy", 64'(a_busy), 64'd0);
    checkOutput("t7_data", 64'(a_bus.led_write_data), 64'd0);
    checkOutput("t7_step", 64'(a_step), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("t7_wr_count", 64'(a_wr - wr0), 64'd0);

    // T3: looping DUT over 3 passes, then stop
    s = cyc;
    pushPlay(1'b1, s, 0, 15);
    applyStimulus(1'b1, 1'b1, 1'b0);
    b_watch = 1'b1;
    repeat (100) @(negedge clk);
    b_watch = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("t3_busy_drops", 64'(b_drops), 64'd0);
    checkOutput("t3_wr_count", 64'(b_wr), 64'd15);
    checkOutput("t3_queue", 64'(b_q.size()), 64'd0);
    checkOutput("t3_stopped", 64'(b_busy), 64'd0);
    checkOutput("final_a_queue", 64'(a_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
